data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH, 128, number of 32-bit words.
REQ-002 Parameter: AW, 7, address width; DEPTH == 2**AW.
REQ-003 Parameter: DW, 32, data width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 CEN  input  1  chip enable, active-low.
REQ-007 WEN  input  1  write enable, active-low, qualified by CEN.
REQ-008 OEN  input  1  output (read) enable, active-low, qualified by CEN.
REQ-009 A  input  AW  word address.
REQ-010 Data2Mem  input  DW  write data.
REQ-011 ReadDataMem  output  DW  read data.
REQ-012 mem_ready  output  1  high once the post-reset clear has finished; CPU reset is released from it.
REQ-013 ld_valid / ld_ready  input / output  1 each  preload handshake.
REQ-014 ld_addr / ld_data  input  AW / DW  preload address and word.
REQ-015 par_err  output  1  sticky parity error flag; tied 0 when DMEM_PARITY_EN is undefined.

Function
REQ-016 FSM states SHALL be CLEAR, READY; reset SHALL enter CLEAR with clear pointer 0.
REQ-017 CLEAR SHALL write 0 to word[ptr] each cycle, ptr+1; at ptr == DEPTH-1 the next state SHALL be READY, so the clear takes exactly DEPTH cycles.
REQ-018 mem_ready SHALL be 0 in CLEAR and 1 in READY, registered.
REQ-019 In CLEAR, CPU strobes and ld_valid SHALL be ignored, and ld_ready SHALL be 0.
REQ-020 CPU write: in READY, when CEN=0 and WEN=0, word[A] SHALL take Data2Mem at the rising edge.
REQ-021 CPU read: when CEN=0 and OEN=0, ReadDataMem SHALL show word[A] combinationally in the same cycle, with zero latency.
REQ-022 When a read is not active, ReadDataMem SHALL hold the last read value, kept in a register updated on each active-read edge; reset value 0.
REQ-023 WEN=0 and OEN=0 together: the write SHALL occur and ReadDataMem SHALL show the pre-write contents.
REQ-024 ld_ready SHALL be 1 only in READY and only when CEN=1; the CPU always wins arbitration.
REQ-025 A preload word SHALL be written on the edge where ld_valid and ld_ready are both 1; ld_valid without ld_ready SHALL leave the memory unchanged.
REQ-026 A SHALL be used modulo DEPTH, with no out-of-range behaviour.

Reset
REQ-027 Reset asserted at any point, including mid-CLEAR or mid-preload, SHALL restart CLEAR from ptr 0.
REQ-028 Outputs during reset: mem_ready=0, ld_ready=0, ReadDataMem=0, par_err=0.
REQ-029 Array contents SHALL NOT be reset asynchronously; only the CLEAR sweep zeroes them.

Configuration
REQ-030 DMEM_PARITY_EN defined: each word SHALL store an even-parity bit computed on every write, including CLEAR writes and preload writes.
REQ-031 With DMEM_PARITY_EN, an active read whose word/parity mismatch SHALL set par_err at the next edge; only reset clears it.
REQ-032 With DMEM_PARITY_EN, the input ld_bad_par (1 bit) SHALL invert the stored parity bit on a preload write; this is for test only.
REQ-033 DMEM_PARITY_EN undefined: no parity storage, no ld_bad_par port, and par_err tied 0.

Structure
REQ-034 Shared package dmem_pkg SHALL hold DEPTH/AW/DW defaults and the FSM state enum.
REQ-035 One sub-module, dmem_array, SHALL be used: storage with one write port and one asynchronous read port, with optional parity bit.
REQ-036 RTL SHALL be 120-400 lines.

Verification
REQ-037 Reset release -> mem_ready rises exactly 128 cycles later; a read of A=0x7F then returns 0x00000000.
REQ-038 In READY, CEN=0, WEN=0, A=5, Data2Mem=0xDEADBEEF; next cycle CEN=0, OEN=0, A=5 -> ReadDataMem=0xDEADBEEF in the same cycle, and held after CEN returns to 1.
REQ-039 ld_valid=1, ld_addr=0x10, ld_data=0x12345678 while CEN=0 for 3 cycles -> ld_ready stays 0 and the word is unchanged; CEN=1 -> handshake completes in one cycle and a read returns 0x12345678.
REQ-040 Reset asserted at clear cycle 60 -> mem_ready stays 0 and rises 128 cycles after the new release.
REQ-041 WEN=0 and OEN=0 at A=3 (old value 0x1, Data2Mem=0x2) -> ReadDataMem=0x1 in that cycle, and 0x2 on the next read.
REQ-042 DMEM_PARITY_EN: preload A=9 with ld_bad_par=1, then read A=9 -> par_err=1 from the next edge and it persists until rst_n=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared defaults and FSM state type for the data memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int unsigned c_depth = 128;
    localparam int unsigned c_aw    = 7;
    localparam int unsigned c_dw    = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_e;

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module   : dmem_array
// Brief    : Word storage, one write port, one asynchronous read port, with an
//            optional even-parity bit per word when DMEM_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = c_depth,
    parameter int AW    = c_aw,
    parameter int DW    = c_dw
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
`ifdef DMEM_PARITY_EN
    input  logic          i_wpar_flip,
    output logic          o_rpar_err,
`endif
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    // Contents are deliberately not reset; the owner zeroes them by sweeping.
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

`ifdef DMEM_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_par[i_waddr] <= (^i_wdata) ^ i_wpar_flip;
        end
    end

    assign o_rpar_err = (^o_rdata) ^ r_par[i_raddr];
`endif

endmodule : dmem_array

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Brief    : CPU data memory with post-reset clear sweep and a preload port
//            that yields to the CPU. Optional parity: DMEM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = c_depth,
    parameter int AW    = c_aw,
    parameter int DW    = c_dw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          OEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] Data2Mem,
    output logic [DW-1:0] ReadDataMem,
    output logic          mem_ready,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
`ifdef DMEM_PARITY_EN
    input  logic          ld_bad_par,
`endif
    output logic          par_err
);

    localparam logic [AW-1:0] c_ptr_last = AW'(DEPTH - 1);

    dmem_state_e   r_state;
    logic [AW-1:0] r_ptr;
    logic          r_mem_ready;
    logic [DW-1:0] r_rd_hold;

    logic          w_in_ready;
    logic          w_cpu_rd;
    logic          w_cpu_wr;
    logic          w_ld_wr;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rdata;
`ifdef DMEM_PARITY_EN
    logic          w_wpar_flip;
    logic          w_rpar_err;
    logic          r_par_err;
`endif

    assign w_in_ready = (r_state == READY);
    assign w_cpu_rd   = w_in_ready & ~CEN & ~OEN;
    assign w_cpu_wr   = w_in_ready & ~CEN & ~WEN;
    // Preload only gets the port while the CPU is deselected.
    assign ld_ready   = w_in_ready & CEN;
    assign w_ld_wr    = ld_valid & ld_ready;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = A;
        w_wdata = Data2Mem;
`ifdef DMEM_PARITY_EN
        w_wpar_flip = 1'b0;
`endif
        if (!w_in_ready) begin
            w_we    = 1'b1;
            w_waddr = r_ptr;
            w_wdata = '0;
        end else if (w_cpu_wr) begin
            w_we    = 1'b1;
        end else if (w_ld_wr) begin
            w_we    = 1'b1;
            w_waddr = ld_addr;
            w_wdata = ld_data;
`ifdef DMEM_PARITY_EN
            w_wpar_flip = ld_bad_par;
`endif
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_array (
        .clk         (clk),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
`ifdef DMEM_PARITY_EN
        .i_wpar_flip (w_wpar_flip),
        .o_rpar_err  (w_rpar_err),
`endif
        .i_raddr     (A),
        .o_rdata     (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CLEAR;
            r_ptr       <= '0;
            r_mem_ready <= 1'b0;
            r_rd_hold   <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_ptr <= r_ptr + AW'(1);
                    if (r_ptr == c_ptr_last) begin
                        r_state     <= READY;
                        r_mem_ready <= 1'b1;
                    end
                end
                READY: begin
                    r_state <= READY;
                end
                default: begin
                    r_state     <= CLEAR;
                    r_mem_ready <= 1'b0;
                end
            endcase
            if (w_cpu_rd) begin
                r_rd_hold <= w_rdata;
            end
        end
    end

    // Array read is pre-write, so a simultaneous write/read returns old data.
    assign ReadDataMem = w_cpu_rd ? w_rdata : r_rd_hold;
    assign mem_ready   = r_mem_ready;

`ifdef DMEM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if (w_cpu_rd && w_rpar_err) begin
            r_par_err <= 1'b1;
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

endmodule : data_mem_responder

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Scoreboard bench: stimulus pushes expected reads from a word-array
//            model, a negedge monitor pops and compares. Parity: DMEM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CEN = 1'b1;
    logic        WEN = 1'b1;
    logic        OEN = 1'b1;
    logic [6:0]  A = '0;
    logic [31:0] Data2Mem = '0;
    logic [31:0] ReadDataMem;
    logic        mem_ready;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [6:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        par_err;
`ifdef DMEM_PARITY_EN
    logic        ld_bad_par = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [128];
    logic [31:0] sb [$];
    logic [31:0] last_exp = '0;
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .CEN         (CEN),
        .WEN         (WEN),
        .OEN         (OEN),
        .A           (A),
        .Data2Mem    (Data2Mem),
        .ReadDataMem (ReadDataMem),
        .mem_ready   (mem_ready),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
`ifdef DMEM_PARITY_EN
        .ld_bad_par  (ld_bad_par),
`endif
        .par_err     (par_err)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every READY-state cycle either a read (pop) or a held value.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_exp = '0;
        end else if (mem_ready) begin
            if (!CEN && !OEN) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: read seen with empty scoreboard, data 0x%08h", ReadDataMem);
                end else begin
                    mon_exp = sb.pop_front();
                    check("rd_data", ReadDataMem, mon_exp);
                    last_exp = mon_exp;
                end
            end else begin
                check("rd_hold", ReadDataMem, last_exp);
            end
        end
    end

    task automatic idle();
        CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; Data2Mem = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) model[i] = '0;
    endtask

    // One READY-state cycle; called at posedge+1, returns at next posedge+1.
    task automatic cycle(input logic cen, input logic wen, input logic oen,
                         input logic [6:0] a, input logic [31:0] d,
                         input logic lv, input logic [6:0] la, input logic [31:0] ldd);
        CEN = cen; WEN = wen; OEN = oen; A = a; Data2Mem = d;
        ld_valid = lv; ld_addr = la; ld_data = ldd;
        if (!cen && !oen) sb.push_back(model[a]);
        #1;
        check("ld_ready", {31'd0, ld_ready}, {31'd0, cen});
        @(posedge clk); #1;
        if (!cen && !wen) model[a] = d;
        else if (lv && cen) model[la] = ldd;
    endtask

    // Clear sweep with garbage strobes; all of it must be ignored.
    task automatic wait_ready(output int n);
        n = 0;
        while (!mem_ready && n < 300) begin
            CEN = 1'($urandom); WEN = 1'($urandom); OEN = 1'($urandom);
            A = 7'($urandom); Data2Mem = $urandom;
            ld_valid = 1'b1; ld_addr = 7'($urandom); ld_data = $urandom;
            #1;
            check("ld_ready_in_clear", {31'd0, ld_ready}, 32'd0);
            @(posedge clk); #1;
            n++;
        end
        idle();
    endtask

    initial begin
        int n;
        logic cen, wen, oen, lv;
        logic [6:0] a, la;

        idle();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("rst_rdata", ReadDataMem, 32'd0);
        check("rst_par_err", {31'd0, par_err}, 32'd0);

        rst_n = 1'b1;
        wait_ready(n);
        check("clear_cycles", n, 32'd128);

        cycle(1'b0, 1'b1, 1'b0, 7'h7F, 32'h0, 1'b0, 7'h0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF, 1'b0, 7'h0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 7'd5, 32'h0, 1'b0, 7'h0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 1'b0, 7'h0, 32'h0);
        check("hold_after_read", ReadDataMem, 32'hDEADBEEF);

        // Preload blocked by CPU select, then completes in one cycle.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 1'b1, 7'd1, 32'h0, 1'b1, 7'h10, 32'h12345678);
        cycle(1'b0, 1'b1, 1'b0, 7'h10, 32'h0, 1'b1, 7'h10, 32'h12345678);
        cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 1'b1, 7'h10, 32'h12345678);
        cycle(1'b0, 1'b1, 1'b0, 7'h10, 32'h0, 1'b0, 7'h0, 32'h0);
        check("preload_word", model[7'h10], 32'h12345678);

        // Simultaneous write and read shows pre-write data.
        cycle(1'b0, 1'b0, 1'b1, 7'd3, 32'h1, 1'b0, 7'h0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 7'd3, 32'h2, 1'b0, 7'h0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 7'd3, 32'h0, 1'b0, 7'h0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            cen = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
            wen = 1'($urandom);
            oen = 1'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 15));
            lv  = 1'($urandom);
            la  = 7'($urandom_range(0, 15));
            cycle(cen, wen, oen, a, $urandom, lv, la, $urandom);
        end
        idle();
        check("par_err_clean", {31'd0, par_err}, 32'd0);

        // Reset in the middle of a clear sweep restarts it.
        rst_n = 1'b0;
        #1;
        check("rst2_rdata", ReadDataMem, 32'd0);
        check("rst2_mem_ready", {31'd0, mem_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midclear_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("midclear_ld_ready", {31'd0, ld_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        wait_ready(n);
        check("clear_cycles_2", n, 32'd128);
        cycle(1'b0, 1'b1, 1'b0, 7'd5, 32'h0, 1'b0, 7'h0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 7'h10, 32'h0, 1'b0, 7'h0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 7'h7F, 32'h0, 1'b0, 7'h0, 32'h0);

`ifdef DMEM_PARITY_EN
        ld_bad_par = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 1'b1, 7'd9, 32'hA5A5_0001);
        ld_bad_par = 1'b0;
        check("par_err_before_read", {31'd0, par_err}, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 7'd9, 32'h0, 1'b0, 7'h0, 32'h0);
        check("par_err_set", {31'd0, par_err}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 7'd5, 32'h0, 1'b0, 7'h0, 32'h0);
        repeat (3) cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 1'b0, 7'h0, 32'h0);
        check("par_err_sticky", {31'd0, par_err}, 32'd1);
        idle();
        rst_n = 1'b0;
        #1;
        check("par_err_reset", {31'd0, par_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
`else
        check("par_err_tied", {31'd0, par_err}, 32'd0);
`endif

        idle();
        @(posedge clk); #1;
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_data_mem_responder

`default_nettype wire
